// File: rtl/score_pkg.sv
// Shared types and helpers for the score tracker: game states, default clamp digits, popcount.
package score_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

  localparam int MAX_SCORE_DEF = 99;
  localparam int MAX_TENS      = MAX_SCORE_DEF / 10;
  localparam int MAX_UNITS     = MAX_SCORE_DEF % 10;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/bcd2_adder.sv
// Two-digit BCD add of a small addend (0..8), clamped to a two-digit BCD ceiling.
module bcd2_adder (
  input  logic [3:0] tens,
  input  logic [3:0] units,
  input  logic [3:0] addend,
  input  logic [3:0] clamp_tens,
  input  logic [3:0] clamp_units,
  output logic [3:0] sum_tens,
  output logic [3:0] sum_units
);
  logic [4:0] u_raw;
  logic       carry;
  logic [3:0] u;
  logic [4:0] t;
  logic       over;

  always_comb begin
    u_raw = {1'b0, units} + {1'b0, addend};
    carry = (u_raw >= 5'd10);
    u     = carry ? 4'(u_raw - 5'd10) : u_raw[3:0];
    t     = {1'b0, tens} + {4'd0, carry};
    // tens may reach 10 before the clamp, hence the 5-bit compare
    over  = (t > {1'b0, clamp_tens}) || ((t == {1'b0, clamp_tens}) && (u > clamp_units));
    sum_tens  = over ? clamp_tens  : t[3:0];
    sum_units = over ? clamp_units : u;
  end
endmodule

// File: rtl/score_tracker.sv
// Edge-detected hit/miss flags drive a saturating score (binary + BCD) and lives in a small game FSM.
module score_tracker #(
  parameter int NUM_CH      = 2,
  parameter int MAX_SCORE   = score_pkg::MAX_SCORE_DEF,
  parameter int SCORE_W     = 7,
  parameter int START_LIVES = 3
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               start,
  input  logic [NUM_CH-1:0]  hit,
  input  logic [NUM_CH-1:0]  miss,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         bcd_tens,
  output logic [3:0]         bcd_units,
  output logic [3:0]         lives,
  output logic               playing,
  output logic               game_over,
  output logic               score_pulse
);
  import score_pkg::*;

  localparam logic [3:0] CLAMP_T = 4'(MAX_SCORE / 10);
  localparam logic [3:0] CLAMP_U = 4'(MAX_SCORE % 10);

  state_t              state;
  logic [NUM_CH-1:0]   hit_prev, miss_prev;
  logic [3:0]          n_hit, n_miss;
  logic [SCORE_W:0]    sum;
  logic [SCORE_W-1:0]  score_nxt;
  logic [3:0]          lives_nxt;
  logic [3:0]          tens_nxt, units_nxt;

  always_comb begin
    n_hit     = popcount(8'(hit & ~hit_prev));
    n_miss    = popcount(8'(miss & ~miss_prev));
    sum       = {1'b0, score} + (SCORE_W+1)'(n_hit);
    score_nxt = (sum > (SCORE_W+1)'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
    lives_nxt = (n_miss >= lives) ? 4'd0 : lives - n_miss;
  end

  bcd2_adder u_bcd (
    .tens        (bcd_tens),
    .units       (bcd_units),
    .addend      (n_hit),
    .clamp_tens  (CLAMP_T),
    .clamp_units (CLAMP_U),
    .sum_tens    (tens_nxt),
    .sum_units   (units_nxt)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      score       <= '0;
      bcd_tens    <= '0;
      bcd_units   <= '0;
      lives       <= '0;
      playing     <= 1'b0;
      game_over   <= 1'b0;
      score_pulse <= 1'b0;
      hit_prev    <= '0;
      miss_prev   <= '0;
    end else begin
      hit_prev    <= hit;
      miss_prev   <= miss;
      score_pulse <= 1'b0;
      case (state)
        IDLE, OVER: if (start) begin
          state     <= PLAY;
          score     <= '0;
          bcd_tens  <= '0;
          bcd_units <= '0;
          lives     <= 4'(START_LIVES);
          playing   <= 1'b1;
          game_over <= 1'b0;
        end
        PLAY: begin
          score       <= score_nxt;
          bcd_tens    <= tens_nxt;
          bcd_units   <= units_nxt;
          score_pulse <= (score_nxt != score);
          lives       <= lives_nxt;
          // the score from the final cycle is kept even when the game ends
          if (lives_nxt == 4'd0) begin
            state     <= OVER;
            playing   <= 1'b0;
            game_over <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
Parametrised successor to the two-channel point counter. Takes NUM_CH per-fruit collision flags and NUM_CH per-fruit miss flags (fruit left the screen uncaught), and edge-detects each one. It keeps a saturating score with a live BCD copy and a lives counter, inside a small game-state machine. It sits between the per-fruit collision detectors / fruit movers and the HEX display decoders and VGA game-over logic.

Parameters:
NUM_CH, 2, number of fruit channels (1..8)
MAX_SCORE, 99, saturation value of score (must be <= 99 so two BCD digits suffice)
SCORE_W, 7, width of binary score (must hold MAX_SCORE)
START_LIVES, 3, lives loaded on start (1..15)

Ports:
Clock  in  1  system clock; all inputs synchronous to it
Resetn  in  1  asynchronous active-low reset
start  in  1  level; begins/restarts a game when sampled high in IDLE or OVER
hit  in  NUM_CH  per-channel collision flag (level, may stay high many cycles)
miss  in  NUM_CH  per-channel fruit-missed flag (level)
score  out  SCORE_W  binary score, saturating at MAX_SCORE
bcd_tens  out  4  tens digit of score (0..9)
bcd_units  out  4  units digit of score (0..9)
lives  out  4  remaining lives
playing  out  1  high in PLAY
game_over  out  1  high in OVER
score_pulse  out  1  one-cycle strobe, high the cycle after any point is actually added

Behaviour:
- Reset (async, Resetn=0): state=IDLE; score=0, bcd_tens=0, bcd_units=0, lives=0, playing=0, game_over=0, score_pulse=0; hit_prev and miss_prev=0.
- Edge detect: new_hit[i] = hit[i] & ~hit_prev[i]; new_miss[i] likewise. Prev registers update every cycle in all states, so a flag already high on entry to PLAY does not count.
- n_hit = popcount(new_hit), n_miss = popcount(new_miss), both computed combinationally each cycle.
- States:
  - IDLE --start--> PLAY. On that edge, load score=0, BCD=0, lives=START_LIVES.
  - PLAY --(lives reaches 0)--> OVER.
  - OVER --start--> PLAY, with the same loads as above.
  - start is ignored in PLAY.
- In PLAY, on each Clock edge:
  - score <= min(score + n_hit, MAX_SCORE). Every simultaneous edge counts; two channels hitting in the same cycle add 2.
  - BCD registers track score exactly, updated in the same cycle. This is a decimal add of n_hit with carry from units to tens, clamped to the BCD of MAX_SCORE. bcd == score at all times.
  - score_pulse <= 1 iff the added amount > 0. It is 0 when already saturated.
  - lives <= lives - n_miss, floored at 0. If the result is 0, the next state is OVER.
- Simultaneous hit and miss in the same cycle: both apply. The score update is kept even if the same cycle ends the game.
- Hits and misses in IDLE/OVER: ignored, and score/lives are held. The OVER state freezes the final score for display.
- Latency: an input rising at cycle k, sampled at edge k, is visible on score/bcd/lives after edge k (1 cycle).
- Flag held high: counts once; it must drop low for at least 1 cycle before it can count again.
- Reset mid-game: returns to IDLE immediately and asynchronously, and all outputs go to their reset values.

Decomposition:
- Package score_pkg holds:
  - state enum (IDLE, PLAY, OVER);
  - localparams MAX_TENS = MAX_SCORE/10 and MAX_UNITS = MAX_SCORE%10;
  - a popcount function.
- One natural sub-module: bcd2_adder. It is combinational: inputs 2-digit BCD, addend 0..8 and the clamp value; outputs the new 2-digit BCD. It is instantiated once and the digit registers live in score_tracker.
- The 7-segment decode stays in the existing display module, driven from bcd_tens/bcd_units.

Test Plan:
- Reset, then start=1 for 1 cycle -> playing=1, lives=3, score=0, bcd=0/0.
- hit[0] held high 20 cycles -> score=1, bcd=0/1, single score_pulse. Drop it, then raise again -> score=2.
- hit=2'b11 rising in the same cycle -> score +2 in one cycle, score_pulse high 1 cycle. From score 9, bcd goes 1/1.
- Preload to 98, then a hit=2'b11 edge -> score=99, bcd=9/9. A further hit edge -> score stays 99, score_pulse=0.
- lives=1, same-cycle hit[0] and miss[1] edges -> score +1, lives=0, game_over=1 next cycle. Later hit edges leave score unchanged. start=1 -> PLAY, score=0, lives=3.
- Resetn pulsed low mid-PLAY (score=37) -> immediately score=0, bcd=0/0, lives=0, state IDLE. A hit held high across start does not count until it re-rises.
